// File: rtl/points_display.sv
// Captures an 8-bit score, converts it to BCD by shift-add-3,
// and drives three active-low 7-segment digits.
module points_display #(
  parameter int P_POINTS = 8,
  parameter bit P_BLANK  = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [P_POINTS-1:0] points,
  input  logic                load,
  output logic                busy,
  output logic                done,
  output logic [6:0]          hex2,
  output logic [6:0]          hex1,
  output logic [6:0]          hex0
);

  localparam int CW = $clog2(P_POINTS + 1);
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [6:0] SEG_LEAD =
    P_BLANK ? SEG_OFF : SEG_ZERO;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SHOW
  } state_t;

  state_t              state_q, state_d;
  logic [P_POINTS-1:0] shift_q, shift_d;
  logic [11:0]         bcd_q, bcd_d;
  logic [11:0]         adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [6:0]          hex2_q, hex2_d;
  logic [6:0]          hex1_q, hex1_d;
  logic [6:0]          hex0_q, hex0_d;

  function automatic logic [6:0] seg7(
    input logic [3:0] d
  );
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Add 3 to every BCD nibble of 5 or more before the shift
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Next-state logic; digits are latched on the final shift
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hex2_d  = hex2_q;
    hex1_d  = hex1_q;
    hex0_d  = hex0_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          shift_d = points;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d   = {adj[10:0], shift_q[P_POINTS-1]};
        shift_d = {shift_q[P_POINTS-2:0], 1'b0};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(P_POINTS - 1)) begin
          state_d = SHOW;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hex0_d  = seg7(bcd_d[3:0]);
          hex1_d  = seg7(bcd_d[7:4]);
          hex2_d  = seg7(bcd_d[11:8]);
          if (P_BLANK && bcd_d[11:8] == 4'd0) begin
            hex2_d = SEG_OFF;
            if (bcd_d[7:4] == 4'd0)
              hex1_d = SEG_OFF;
          end
        end
      end
      SHOW: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs with synchronous reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hex2_q  <= SEG_LEAD;
      hex1_q  <= SEG_LEAD;
      hex0_q  <= SEG_ZERO;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hex2_q  <= hex2_d;
      hex1_q  <= hex1_d;
      hex0_q  <= hex0_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hex2 = hex2_q;
  assign hex1 = hex1_q;
  assign hex0 = hex0_q;

endmodule

// File: doc/points_display.md
Name: points_display

Overview:
- Consumer end of the score path: takes the 8-bit `points` value produced by the scoring logic when a game ends.
- Captures `points` on a load strobe and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Drives three active-low 7-segment displays (hundreds, tens, units) until the next load.
- Sits between the scoring logic and the board HEX outputs.

Parameters:
- P_POINTS, 8, width of the `points` input; fixes the conversion length at P_POINTS shift cycles.
- P_BLANK, 1, 1 = leading-zero digits blanked (all segments off); 0 = leading zeros shown as "0".

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of `clock`.
- points  input  P_POINTS  score to display; sampled only in the cycle `load` is accepted.
- load  input  1  one-cycle request to capture `points` and start a conversion.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new digits appear on the HEX outputs.
- hex2  output  7  hundreds digit; segments {g,f,e,d,c,b,a}; active-low.
- hex1  output  7  tens digit; same segment order and polarity.
- hex0  output  7  units digit; same segment order and polarity.

Behaviour:
- Reset (`reset`=0 at a clock edge):
  - FSM goes to IDLE; busy=0, done=0.
  - Shift register, BCD register and shift counter cleared.
  - Displayed digits = 0,0,0, so hex0=7'b1000000.
  - hex1/hex2 = 7'b1111111 if P_BLANK=1, else 7'b1000000.
  - Reset overrides everything, including a conversion in progress and a simultaneous `load`.
- FSM states: IDLE, CONV, SHOW.
- IDLE:
  - On load=1: capture `points` into the shift register, clear BCD to 0, counter=0, busy=1 next cycle, go to CONV.
  - Otherwise hold; HEX outputs keep their last values.
- CONV, once per cycle:
  - Each BCD nibble ≥5 gets +3.
  - Then {BCD, shift} shifts left by 1.
  - Counter increments.
  - After P_POINTS shift cycles, go to SHOW.
  - BCD width is 12 bits for P_POINTS=8; max 255 -> 2,5,5.
- SHOW (one cycle):
  - Latch the BCD digits into the display registers; HEX outputs change this cycle.
  - done=1 and busy=0 in the same cycle.
  - Return to IDLE.
- Latency:
  - `load` accepted at edge t -> busy=1 from t+1 through t+P_POINTS.
  - done=1 and new HEX values at t+P_POINTS+1, i.e. 9 cycles for the default.
- `load` while busy=1 or in SHOW: ignored, with no queueing; the in-flight conversion completes with its original value.
- `load` in the same cycle done=1: ignored. A new load is accepted only in IDLE.
- HEX outputs are stable during CONV and show the previous result; they are never intermediate values.
- Blanking (P_BLANK=1):
  - hex2 blank when the hundreds digit = 0.
  - hex1 blank when hundreds = 0 and tens = 0.
  - hex0 always shown.
- Segment encoding, active-low, {g..a}:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - Non-BCD nibble (unreachable) = 1111111.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset with P_BLANK=1 -> busy=0, done=0, hex0=1000000, hex1=hex2=1111111; same result after asserting reset mid-CONV.
- load=1 with points=8'd255 -> busy high 8 cycles, done pulse on cycle 9; hex2=0100100 ("2"), hex1=0010010 ("5"), hex0=0010010 ("5").
- points=8'd7 -> hex2=hex1=1111111, hex0=1111000; repeat with P_BLANK=0 -> hex2=hex1=1000000.
- points=8'd105 -> hex2=1111001, hex1=1000000 (inner zero not blanked), hex0=0010010.
- Load 8'd42, then pulse load with 8'd99 at cycle 3 of CONV and again in the done cycle -> display shows 4,2; exactly one done pulse; a later load of 99 in IDLE shows 9,9.
- Back-to-back: loads of 0 and then 200, each issued in IDLE -> first shows hex0=1000000 with upper digits blank; second shows 2,0,0 with hex1=1000000 shown.
